// File: rtl/gam_pattern_sequencer_pkg.sv
// Shared types and default sizes for the GAM pattern sequencer.
// The store, the sequencer and their users import these definitions.
package GAM_package;

    localparam int CLASS_COUNT = 4;
    localparam int NODE_COUNT  = 5;
    localparam int NODE_WIDTH  = 128;

    typedef logic [NODE_WIDTH-1:0] node_vector_T;

    typedef enum logic {
        LEARNING = 1'b0,
        RECALL   = 1'b1
    } LEARNING_RECALL_T;

    typedef enum logic {
        WAIT  = 1'b0,
        READY = 1'b1
    } READY_WAIT_T;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } SEQ_STATE_T;

    // Index width that stays legal when a dimension collapses to a single entry.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/gam_pattern_sequencer_store.sv
// Pattern memory: CLASS_COUNT x NODE_COUNT vectors, synchronous write,
// combinational read, deliberately without reset so contents survive a run abort.
module gam_pattern_store
    import GAM_package::*;
#(
    parameter int CLASS_COUNT = GAM_package::CLASS_COUNT,
    parameter int NODE_COUNT  = GAM_package::NODE_COUNT,
    parameter int NODE_WIDTH  = GAM_package::NODE_WIDTH,
    localparam int CW = idx_width(CLASS_COUNT),
    localparam int NW = idx_width(NODE_COUNT)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [CW-1:0]         wr_class,
    input  logic [NW-1:0]         wr_node,
    input  logic [NODE_WIDTH-1:0] wr_data,
    input  logic [CW-1:0]         rd_class,
    input  logic [NW-1:0]         rd_node,
    output logic [NODE_WIDTH-1:0] rd_data
);

    logic [NODE_WIDTH-1:0] mem [CLASS_COUNT][NODE_COUNT];
    logic                  wr_in_range;

    // Index encodings beyond the array bounds are silently ignored.
    assign wr_in_range = (int'(wr_class) < CLASS_COUNT) && (int'(wr_node) < NODE_COUNT);

    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_class][wr_node] <= wr_data;
        end
    end

    assign rd_data = mem[rd_class][rd_node];

endmodule

// File: rtl/gam_pattern_sequencer.sv
// Streams stored node patterns class by class to the Memory_Layer,
// advancing one pattern per READY handshake.
module gam_pattern_sequencer
    import GAM_package::*;
#(
    parameter int CLASS_COUNT = GAM_package::CLASS_COUNT,
    parameter int NODE_COUNT  = GAM_package::NODE_COUNT,
    parameter int NODE_WIDTH  = GAM_package::NODE_WIDTH,
    localparam int CW = idx_width(CLASS_COUNT),
    localparam int NW = idx_width(NODE_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [CW-1:0]         load_class,
    input  logic [NW-1:0]         load_node,
    input  logic [NODE_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic [CW-1:0]         class_last,
    input  logic [NW-1:0]         node_last,
    input  LEARNING_RECALL_T      mode,
    input  logic                  start,
    input  READY_WAIT_T           ready_wait,
    output logic [NODE_WIDTH-1:0] x,
    output logic [31:0]           c,
    output LEARNING_RECALL_T      learning_recall,
    output logic                  learning_done,
    output logic                  busy,
    output logic                  zero_err
);

    SEQ_STATE_T            state;
    SEQ_STATE_T            state_nxt;
    logic [CW-1:0]         class_idx;
    logic [CW-1:0]         class_last_q;
    logic [CW-1:0]         class_last_cl;
    logic [CW-1:0]         class_nxt;
    logic [CW-1:0]         rd_class;
    logic [NW-1:0]         node_idx;
    logic [NW-1:0]         node_last_q;
    logic [NW-1:0]         node_last_cl;
    logic [NW-1:0]         node_nxt;
    logic [NW-1:0]         rd_node;
    logic [NODE_WIDTH-1:0] store_rd;
    logic                  start_run;
    logic                  consume;
    logic                  at_last;
    logic                  wr_en;

    assign class_last_cl = (class_last > CW'(CLASS_COUNT - 1)) ? CW'(CLASS_COUNT - 1) : class_last;
    assign node_last_cl  = (node_last > NW'(NODE_COUNT - 1)) ? NW'(NODE_COUNT - 1) : node_last;

    assign start_run = (state == IDLE) && start;
    assign consume   = (state == STREAM) && (ready_wait == READY);
    assign at_last   = (class_idx == class_last_q) && (node_idx == node_last_q);
    // A start in the same cycle takes priority and the write is dropped.
    assign wr_en     = load_valid && load_ready && !start;

    always_comb begin
        class_nxt = class_idx;
        node_nxt  = node_idx;
        if (node_idx == node_last_q) begin
            node_nxt  = '0;
            class_nxt = class_idx + 1'b1;
        end else begin
            node_nxt  = node_idx + 1'b1;
        end
    end

    // Look ahead at the pattern that will be registered into x on this edge.
    assign rd_class = start_run ? '0 : class_nxt;
    assign rd_node  = start_run ? '0 : node_nxt;

    gam_pattern_store #(
        .CLASS_COUNT (CLASS_COUNT),
        .NODE_COUNT  (NODE_COUNT),
        .NODE_WIDTH  (NODE_WIDTH)
    ) u_store (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_class (load_class),
        .wr_node  (load_node),
        .wr_data  (load_data),
        .rd_class (rd_class),
        .rd_node  (rd_node),
        .rd_data  (store_rd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (consume && at_last) state_nxt = DONE;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready    = (state == IDLE);
        busy          = (state == STREAM);
        learning_done = (learning_recall == LEARNING) && at_last &&
                        ((state == STREAM) || (state == DONE));
    end

    // Run configuration, position and the registered pattern/class outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            class_idx       <= '0;
            node_idx        <= '0;
            class_last_q    <= '0;
            node_last_q     <= '0;
            learning_recall <= LEARNING;
            x               <= '0;
            c               <= '0;
            zero_err        <= 1'b0;
        end else if (start_run) begin
            class_idx       <= '0;
            node_idx        <= '0;
            class_last_q    <= class_last_cl;
            node_last_q     <= node_last_cl;
            learning_recall <= mode;
            x               <= store_rd;
            c               <= 32'd1;
            zero_err        <= 1'b0;
        end else if (consume) begin
            if (x == '0) begin
                zero_err <= 1'b1;
            end
            if (!at_last) begin
                class_idx <= class_nxt;
                node_idx  <= node_nxt;
                x         <= store_rd;
                c         <= 32'(class_nxt) + 32'd1;
            end
        end
    end

endmodule

// File: doc/gam_pattern_sequencer.md
GAM_PATTERN_SEQUENCER -- requirements
Module: gam_pattern_sequencer

Interface
REQ-001 Parameters SHALL be: CLASS_COUNT, default 4, number of classes stored; NODE_COUNT, default 5, nodes per class; NODE_WIDTH, default 128, bits per node vector.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low.
- load_valid  in  1  write request into pattern store.
- load_class  in  $clog2(CLASS_COUNT)  store class index (0-based).
- load_node  in  $clog2(NODE_COUNT)  store node index (0-based).
- load_data  in  NODE_WIDTH  pattern to store.
- load_ready  out  1  store accepts writes.
- class_last  in  $clog2(CLASS_COUNT)  last class to stream.
- node_last  in  $clog2(NODE_COUNT)  last node per class.
- mode  in  LEARNING_RECALL_T  run mode, latched at start.
- start  in  1  begin a run.
- ready_wait  in  READY_WAIT_T  Memory_Layer handshake.
- x  out  NODE_WIDTH  current node pattern.
- c  out  32  current class number, 1-based.
- learning_recall  out  LEARNING_RECALL_T  latched mode.
- learning_done  out  1  current pattern is final pattern of a LEARNING run.
- busy  out  1  run in progress.
- zero_err  out  1  sticky: an all-zero pattern was streamed.

Function
REQ-003 FSM states SHALL be IDLE, STREAM, DONE.
REQ-004 load_ready SHALL be 1 only in IDLE; a write SHALL occur on a clock with load_valid & load_ready & !start.
REQ-005 In IDLE, start=1 SHALL latch mode, class_last, node_last (each clamped to CLASS_COUNT-1 / NODE_COUNT-1), set class/node indices to 0, register x=store[0][0], c=1, and enter STREAM next cycle.
REQ-006 start and load_valid in the same IDLE cycle: start SHALL win; the write SHALL be dropped.
REQ-007 In STREAM, a pattern SHALL be consumed on each clock edge where ready_wait==READY; on WAIT, x, c and indices SHALL hold.
REQ-008 On consume, not last: node SHALL increment; when node==node_last, node SHALL wrap to 0 and class SHALL increment; x/c SHALL show the new pattern on the following cycle (one-cycle latency).
REQ-009 On consume of the last pattern (class==class_last & node==node_last) the FSM SHALL enter DONE; x and c SHALL hold.
REQ-010 learning_done SHALL be 1 while x holds the last pattern in a LEARNING run (STREAM and DONE); 0 in RECALL runs and in IDLE.
REQ-011 busy SHALL be 1 in STREAM, 0 otherwise.
REQ-012 DONE SHALL return to IDLE on the first cycle with start=0; start held high SHALL keep DONE (no auto-restart).
REQ-013 zero_err SHALL set when a consumed pattern equals zero; it SHALL clear only on reset or on a new start.
REQ-014 start in STREAM or DONE SHALL be ignored.
REQ-015 c SHALL equal class index + 1, zero-extended to 32 bits.

Reset
REQ-016 reset=0 at a clock edge SHALL force IDLE, x=0, c=0, learning_recall=LEARNING, learning_done=0, busy=0, zero_err=0, indices=0.
REQ-017 Reset mid-STREAM SHALL abort the run at once; pattern store contents SHALL NOT be cleared.

Structure
REQ-018 NODE_WIDTH default, the sequencer state enum SEQ_STATE_T, and the existing node_vector_T, LEARNING_RECALL_T, READY_WAIT_T, CLASS_COUNT, NODE_COUNT SHALL be in GAM_package.
REQ-019 Storage SHALL be the sub-module gam_pattern_store: CLASS_COUNT x NODE_COUNT x NODE_WIDTH, synchronous write, combinational read, no reset.

Verification
REQ-020 Load class0 nodes 0..4 = 1234, 22313, 324234, 123000000000000, {54,54754654,32432432,675656}; class_last=0, node_last=4, LEARNING, ready_wait always READY -> x follows the five values on consecutive cycles, c=1, learning_done=1 only on the fifth, DONE.
REQ-021 Same load, ready_wait=WAIT for 3 cycles after the 2nd pattern -> x=22313 holds 3 cycles, no pattern skipped or repeated.
REQ-022 Two classes, node_last=1, RECALL -> c sequence 1,1,2,2; wrap at node 1; learning_done stays 0.
REQ-023 Store node 2 = 0, stream 5 nodes -> zero_err rises after 3rd consume, stays high through DONE, clears on next start.
REQ-024 reset=0 during 3rd pattern -> next cycle IDLE, all outputs at reset values; restart streams from store[0][0] with contents intact.
REQ-025 start held through DONE, and start+load_valid in IDLE -> FSM stays DONE until start=0; simultaneous write is dropped.
